// File: rtl/sdram_bridge_pkg.sv
// Shared types and defaults for the Wishbone-to-SDRAM-controller bridge.
package sdram_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_HOLD,
      ST_ACK,
      ST_GAP
   } state_t;

   localparam int DEF_ACK_DLY = 2;
   localparam int DEF_RST_DLY = 3;
   localparam int DEF_TMO     = 255;

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after the last grant wins.
module rr_arbiter #(
   parameter int NCH = 2,
   parameter int LGW = 1
) (
   input  logic [NCH-1:0] req,
   input  logic [LGW-1:0] last,
   output logic [NCH-1:0] gnt,
   output logic [LGW-1:0] idx
);

   logic        found;
   int unsigned c;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      c     = 0;
      for (int unsigned i = 1; i <= NCH; i++) begin
         c = (32'(last) + i) % NCH;
         if (!found && req[c]) begin
            found  = 1'b1;
            gnt[c] = 1'b1;
            idx    = LGW'(c);
         end
      end
   end

endmodule

// File: rtl/sdram_wb_bridge.sv
// Multi-channel Wishbone front end for a req/ack SDRAM controller: reset
// sequencing, round-robin arbitration, per-transaction DQM and delayed ack.
module sdram_wb_bridge
   import sdram_bridge_pkg::*;
#(
   parameter int NCH     = 2,
   parameter int AW      = 21,
   parameter int DW      = 16,
   parameter int SW      = DW / 8,
   parameter int RST_DLY = DEF_RST_DLY,
   parameter int ACK_DLY = DEF_ACK_DLY,
   parameter int TMO     = DEF_TMO
) (
   input  logic              clk_p,
   input  logic              reset,
   input  logic              soft_rst,
   input  logic [NCH-1:0]    wb_stb,
   input  logic [NCH-1:0]    wb_we,
   input  logic [NCH*SW-1:0] wb_sel,
   input  logic [NCH*AW-1:0] wb_adr,
   input  logic [NCH*DW-1:0] wb_dat_i,
   output logic [DW-1:0]     wb_dat_o,
   output logic [NCH-1:0]    wb_ack,
   output logic              ctl_rst_n,
   input  logic              ctl_ready,
   output logic              ctl_wr_req,
   output logic              ctl_rd_req,
   input  logic              ctl_wr_ack,
   input  logic              ctl_rd_ack,
   output logic [AW-1:0]     ctl_addr,
   output logic [SW-1:0]     ctl_byteen,
   output logic [DW-1:0]     ctl_wdata,
   input  logic [DW-1:0]     ctl_rdata,
   output logic [SW-1:0]     dqm,
   output logic              tmo_err
);

   localparam int LGW = clog2(NCH);
   localparam int TW  = clog2(TMO + 1);

   state_t         state;
   logic           soft_s1, soft_s2;
   logic [3:0]     rst_cnt;
   logic [LGW-1:0] lgrant, g_idx, arb_idx;
   logic [NCH-1:0] arb_gnt;
   logic [2:0]     hold_cnt;
   logic [TW-1:0]  tmo_cnt;
   logic           l_we;

   rr_arbiter #(
      .NCH (NCH),
      .LGW (LGW)
   ) u_arb (
      .req  (wb_stb),
      .last (lgrant),
      .gnt  (arb_gnt),
      .idx  (arb_idx)
   );

   // Controller reset: held low by the synchronised soft reset, released RST_DLY cycles later.
   always_ff @(posedge clk_p or posedge reset) begin
      if (reset) begin
         soft_s1   <= 1'b0;
         soft_s2   <= 1'b0;
         rst_cnt   <= '0;
         ctl_rst_n <= 1'b0;
      end else begin
         soft_s1 <= soft_rst;
         soft_s2 <= soft_s1;
         if (soft_s2) begin
            ctl_rst_n <= 1'b0;
            rst_cnt   <= '0;
         end else if (!ctl_rst_n) begin
            if (rst_cnt == 4'(RST_DLY - 1)) ctl_rst_n <= 1'b1;
            else                            rst_cnt   <= rst_cnt + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_p or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         lgrant     <= LGW'(NCH - 1);
         g_idx      <= '0;
         l_we       <= 1'b0;
         ctl_addr   <= '0;
         ctl_byteen <= '0;
         ctl_wdata  <= '0;
         dqm        <= '0;
         ctl_wr_req <= 1'b0;
         ctl_rd_req <= 1'b0;
         wb_ack     <= '0;
         wb_dat_o   <= '0;
         tmo_err    <= 1'b0;
         hold_cnt   <= '0;
         tmo_cnt    <= '0;
      end else begin
         wb_ack  <= '0;
         tmo_err <= 1'b0;
         if (soft_s2) begin
            state      <= ST_IDLE;
            ctl_wr_req <= 1'b0;
            ctl_rd_req <= 1'b0;
            dqm        <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (ctl_rst_n && ctl_ready && (arb_gnt != '0)) begin
                     g_idx      <= arb_idx;
                     l_we       <= wb_we[arb_idx];
                     ctl_addr   <= wb_adr[int'(arb_idx)*AW +: AW];
                     ctl_byteen <= wb_sel[int'(arb_idx)*SW +: SW];
                     ctl_wdata  <= wb_dat_i[int'(arb_idx)*DW +: DW];
                     dqm        <= wb_we[arb_idx] ? ~wb_sel[int'(arb_idx)*SW +: SW] : '0;
                     tmo_cnt    <= '0;
                     state      <= ST_REQ;
                  end
               end
               ST_REQ: begin
                  // The request level is raised on the first REQ edge, so an ack only counts once it is up.
                  if ((ctl_wr_req || ctl_rd_req) && (ctl_wr_ack || ctl_rd_ack)) begin
                     ctl_wr_req <= 1'b0;
                     ctl_rd_req <= 1'b0;
                     if (!l_we) wb_dat_o <= ctl_rdata;
                     hold_cnt   <= 3'(ACK_DLY - 1);
                     state      <= ST_HOLD;
                  end else if (tmo_cnt == TW'(TMO - 1)) begin
                     ctl_wr_req <= 1'b0;
                     ctl_rd_req <= 1'b0;
                     tmo_err    <= 1'b1;
                     state      <= ST_GAP;
                  end else begin
                     tmo_cnt    <= tmo_cnt + 1'b1;
                     ctl_wr_req <= l_we;
                     ctl_rd_req <= !l_we;
                  end
               end
               ST_HOLD: begin
                  if (hold_cnt == '0) state    <= ST_ACK;
                  else                hold_cnt <= hold_cnt - 3'd1;
               end
               ST_ACK: begin
                  if (wb_stb[g_idx]) wb_ack[g_idx] <= 1'b1;
                  lgrant <= g_idx;
                  state  <= ST_GAP;
               end
               ST_GAP: begin
                  dqm   <= '0;
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
